kmeans_regfile: RTL and testbench
=================================

# kmeans_regfile

Host-side register file and loader sitting on the opposite end of the k-means core's regfile interface. It accepts host configuration, streams data points into the core's point RAM, and pulses `go`. It then captures the converged centroids that the core writes back over `reg_num`/`reg_w_r`/`reg_write_data`, and raises a host interrupt when the core signals completion on `interuptt`.

## Interface
Parameters:
- `addrWidth`, 9, point-RAM address width
- `dataWidth`, 91, point/centroid word width (7 coordinates x 13 bits)
- `centroid_num`, 8, number of centroid slots captured
- `host_addr_width`, 6, host register address width

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `host_wr`  in  1  host register write strobe
- `host_rd`  in  1  host register read strobe
- `host_addr`  in  `host_addr_width`  register address
- `host_wdata`  in  32  write data
- `host_rdata`  out  32  read data, registered
- `host_irq`  out  1  level interrupt, equal to `done & irq_en`
- `pt_valid`  in  1  point stream valid
- `pt_data`  in  `dataWidth`  point word
- `pt_ready`  out  1  point stream ready; high only in LOAD
- `ram_address`  out  `addrWidth`  core RAM address during load
- `ram_data`  out  `dataWidth`  core RAM write data
- `w_r_ram`  out  1  1 = write strobe to core RAM
- `go`  out  1  one-cycle start pulse to the core
- `first_ram_address`, `last_ram_address`  out  `addrWidth`  held copies of the FIRST/LAST registers
- `reg_num`  in  `addrWidth`  centroid index written by the core
- `reg_w_r`  in  1  centroid write strobe from the core
- `reg_write_data`  in  `dataWidth`  centroid value
- `interuptt`  in  1  core completion indication; level or pulse

## Operation
Register map (word addresses):
- 0x00 CTRL, write-only fields:
  - bit0 `start`, self-clearing
  - bit1 `irq_en`, sticky, reads back
  - bit2 `clr_done`
- 0x01 STATUS, read-only: bit0 busy (state != IDLE), bit1 done, bit2 err, bits5:3 state encoding (IDLE=0, LOAD=1, GO=2, RUN=3, DONE=4)
- 0x02 FIRST and 0x03 LAST: `addrWidth` bits; writable only in IDLE, writes in other states are ignored
- 0x04 PT_CNT, read-only: number of points written in the current or last load
- 0x10 + 4k + w, for k in 0..7 and w in 0..2: centroid k, bits [32w+31:32w]; w=2 returns bits 90:64 zero-extended; w=3 reads 0
- Unmapped reads return 0.

FSM:
- **IDLE**
  - `start` with LAST >= FIRST: clear PT_CNT and all centroid slots, set the load pointer to FIRST, go to LOAD.
  - `start` with LAST < FIRST: set err, stay in IDLE.
- **LOAD**
  - `pt_ready` = 1. Each accepted beat (`pt_valid & pt_ready`) registers address/data, increments the pointer and PT_CNT.
  - The beat at address LAST is the final one; `pt_ready` drops the next cycle and the FSM goes to GO.
- **GO**: `go` = 1 for exactly one cycle, then RUN.
- **RUN**
  - `reg_w_r` with `reg_num < centroid_num` stores `reg_write_data` into slot `reg_num`.
  - `reg_num >= centroid_num` sets err and stores nothing.
  - `interuptt` high moves the FSM to DONE and sets done.
- **DONE**: hold. `clr_done` clears done and returns to IDLE.

Other rules:
- `start` outside IDLE is ignored.
- `reg_w_r` outside RUN is ignored.
- err is cleared only by `clr_done` or reset.
- Centroid slots hold their values until the next accepted start.

## Timing
- Reset values: every output is 0; state is IDLE; FIRST, LAST, PT_CNT, `irq_en`, done, err and all centroid slots are 0.
- Reset asserted mid-operation: abort immediately to the above; any partial RAM load is abandoned.
- Host write takes effect at the clock edge where `host_wr` is sampled. Host read: `host_rdata` is valid in the cycle after `host_rd` and holds until the next read.
- Start at edge t:
  - state = LOAD from t+1; `pt_ready` = 1 in cycle t+1.
  - A beat accepted at edge u appears on `ram_address`/`ram_data` with `w_r_ram` = 1 during cycle u+1, for one cycle.
  - Back-to-back beats give one write per cycle.
- Final beat accepted at edge u: `w_r_ram` is high in cycle u+1 and `go` is high in cycle u+2.
- `interuptt` sampled high in RUN at edge v: done = 1 and `host_irq` (if enabled) from cycle v+1.
- Core centroid write at edge v is readable by a host read issued at v+1 or later.
- Simultaneous events:
  - `interuptt` and a `reg_w_r` in the same RUN cycle: the write is stored, then the FSM moves to DONE.
  - `clr_done` and `start` in one CTRL write while in DONE: `clr_done` wins, FSM returns to IDLE, `start` is ignored.
  - `host_wr` to FIRST in the same cycle as a `start` in IDLE: the old FIRST value is used.
- Pointer never wraps: LAST <= 2^addrWidth-1 is guaranteed by the LAST >= FIRST check.

## Test plan
- Load of 4 points: FIRST=5, LAST=8, `pt_valid` held high → four write cycles with addresses 5, 6, 7, 8 back-to-back; `go` high exactly 2 cycles after the last accept; PT_CNT=4; STATUS state=3.
- Backpressure: `pt_valid` toggling 1,0,0,1,… over the same range → writes only on accepted beats, addresses contiguous, no duplicates.
- Centroid capture: in RUN, `reg_w_r` with `reg_num`=3, data=91'h1_2345_6789_ABCD_EF01_2345, then `interuptt` → reads at 0x1C/0x1D/0x1E return EF012345 / 6789ABCD / 00012345; done=1; `host_irq`=1 with `irq_en`=1, 0 with `irq_en`=0.
- Error paths: start with FIRST=10, LAST=9 → err=1, state stays IDLE, no `pt_ready`; `reg_num`=8 in RUN → err=1, no slot changed.
- Reset mid-LOAD after 2 of 6 beats → all outputs 0, state IDLE, PT_CNT=0; a new start reloads correctly from FIRST.
- Ignored inputs: `start` during RUN and a write to FIRST during LOAD → no effect; a CTRL write of 0x5 (`start` + `clr_done`) in DONE → IDLE, no `go`.

Source files
------------

// File: rtl/kmeans_regfile.sv
// kmeans_regfile: host register file, point loader and centroid capture
// for the k-means core's regfile interface.
module kmeans_regfile #(
   parameter int addrWidth       = 9,
   parameter int dataWidth       = 91,
   parameter int centroid_num    = 8,
   parameter int host_addr_width = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       host_wr,
   input  logic                       host_rd,
   input  logic [host_addr_width-1:0] host_addr,
   input  logic [31:0]                host_wdata,
   output logic [31:0]                host_rdata,
   output logic                       host_irq,
   input  logic                       pt_valid,
   input  logic [dataWidth-1:0]       pt_data,
   output logic                       pt_ready,
   output logic [addrWidth-1:0]       ram_address,
   output logic [dataWidth-1:0]       ram_data,
   output logic                       w_r_ram,
   output logic                       go,
   output logic [addrWidth-1:0]       first_ram_address,
   output logic [addrWidth-1:0]       last_ram_address,
   input  logic [addrWidth-1:0]       reg_num,
   input  logic                       reg_w_r,
   input  logic [dataWidth-1:0]       reg_write_data,
   input  logic                       interuptt
);

   localparam int CW = $clog2(centroid_num);
   localparam logic [addrWidth-1:0] CN = addrWidth'(centroid_num);

   localparam logic [host_addr_width-1:0] A_CTRL  = host_addr_width'(0);
   localparam logic [host_addr_width-1:0] A_STAT  = host_addr_width'(1);
   localparam logic [host_addr_width-1:0] A_FIRST = host_addr_width'(2);
   localparam logic [host_addr_width-1:0] A_LAST  = host_addr_width'(3);
   localparam logic [host_addr_width-1:0] A_PTCNT = host_addr_width'(4);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      GO   = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [addrWidth-1:0] first_q, last_q, ptr_q, ram_addr_q;
   logic [addrWidth:0]   ptcnt_q;
   logic [dataWidth-1:0] ram_data_q;
   logic [dataWidth-1:0] cent_q [centroid_num];
   logic                 irq_en_q, done_q, err_q, wr_q, go_q;
   logic [31:0]          rdata_q, rd_d;

   logic wr_ctrl, start_w, clr_w, accept, busy;
   logic start_ok, start_bad, cent_we, cent_bad, done_set;
   logic cent_hit;
   logic [2:0]  rd_k;
   logic [95:0] cw;
   logic        unused_wdata;

   assign wr_ctrl  = host_wr && (host_addr == A_CTRL);
   assign start_w  = wr_ctrl && host_wdata[0];
   assign clr_w    = wr_ctrl && host_wdata[2];
   assign pt_ready = (state_q == LOAD);
   assign accept   = pt_valid && pt_ready;
   assign busy     = (state_q != IDLE);

   assign unused_wdata = ^host_wdata[31:addrWidth];

   // Next-state decode plus the one-cycle strobes each state produces
   always_comb begin
      state_d   = state_q;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      cent_we   = 1'b0;
      cent_bad  = 1'b0;
      done_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_w) begin
               if (last_q >= first_q) begin
                  start_ok = 1'b1;
                  state_d  = LOAD;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         LOAD: begin
            if (accept && (ptr_q == last_q)) state_d = GO;
         end
         GO: state_d = RUN;
         RUN: begin
            if (reg_w_r) begin
               if (reg_num < CN) cent_we = 1'b1;
               else cent_bad = 1'b1;
            end
            if (interuptt) begin
               state_d  = DONE;
               done_set = 1'b1;
            end
         end
         DONE: begin
            if (clr_w) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Host-visible config and status bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q  <= '0;
         last_q   <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (host_wr && state_q == IDLE && host_addr == A_FIRST)
            first_q <= host_wdata[addrWidth-1:0];
         if (host_wr && state_q == IDLE && host_addr == A_LAST)
            last_q <= host_wdata[addrWidth-1:0];
         if (wr_ctrl) irq_en_q <= host_wdata[1];
         if (clr_w) done_q <= 1'b0;
         else if (done_set) done_q <= 1'b1;
         if (clr_w) err_q <= 1'b0;
         if (start_bad || cent_bad) err_q <= 1'b1;
      end
   end

   // Point loader: register each accepted beat as a one-cycle RAM write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         ptcnt_q    <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         wr_q       <= 1'b0;
         go_q       <= 1'b0;
      end else begin
         wr_q <= accept;
         go_q <= (state_q == GO);
         if (start_ok) begin
            ptr_q   <= first_q;
            ptcnt_q <= '0;
         end else if (accept) begin
            ram_addr_q <= ptr_q;
            ram_data_q <= pt_data;
            ptr_q      <= ptr_q + 1'b1;
            ptcnt_q    <= ptcnt_q + 1'b1;
         end
      end
   end

   // Centroid slots: cleared on accepted start, written by the core in RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < centroid_num; i++) cent_q[i] <= '0;
      end else if (start_ok) begin
         for (int i = 0; i < centroid_num; i++) cent_q[i] <= '0;
      end else if (cent_we) begin
         cent_q[reg_num[CW-1:0]] <= reg_write_data;
      end
   end

   // Centroid window 0x10..0x2F: slot from bits 5 and 3:2, word from 1:0
   assign cent_hit = host_addr[5] ^ host_addr[4];
   assign rd_k     = {host_addr[5], host_addr[3:2]};
   assign cw       = 96'(cent_q[rd_k]);

   // Host read mux
   always_comb begin
      rd_d = '0;
      case (host_addr)
         A_CTRL:  rd_d = {30'd0, irq_en_q, 1'b0};
         A_STAT:  rd_d = {26'd0, state_q, err_q, done_q, busy};
         A_FIRST: rd_d = 32'(first_q);
         A_LAST:  rd_d = 32'(last_q);
         A_PTCNT: rd_d = 32'(ptcnt_q);
         default: begin
            if (cent_hit) begin
               case (host_addr[1:0])
                  2'd0:    rd_d = cw[31:0];
                  2'd1:    rd_d = cw[63:32];
                  2'd2:    rd_d = cw[95:64];
                  default: rd_d = '0;
               endcase
            end
         end
      endcase
   end

   // Registered read data, held until the next read
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rdata_q <= '0;
      else if (host_rd) rdata_q <= rd_d;
   end

   assign host_rdata        = rdata_q;
   assign host_irq          = done_q & irq_en_q;
   assign ram_address       = ram_addr_q;
   assign ram_data          = ram_data_q;
   assign w_r_ram           = wr_q;
   assign go                = go_q;
   assign first_ram_address = first_q;
   assign last_ram_address  = last_q;

endmodule

// File: tb/tb_kmeans_regfile.sv
// tb_kmeans_regfile: directed vectors for the k-means host register file.
// Expected values are hand-computed from the register map and timing.
module tb_kmeans_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_wr, host_rd;
   logic [5:0]  host_addr;
   logic [31:0] host_wdata, host_rdata;
   logic        host_irq;
   logic        pt_valid, pt_ready;
   logic [90:0] pt_data, ram_data, reg_write_data;
   logic [8:0]  ram_address, first_ram_address, last_ram_address, reg_num;
   logic        w_r_ram, go, reg_w_r, interuptt;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [90:0] D3 = 91'h1_2345_6789_ABCD_EF01_2345;
   localparam logic [90:0] D5 = 91'h5_AAAB_BBBC_CCCD_DDDE_EEEF;

   kmeans_regfile dut (
      .clk(clk), .rst(rst),
      .host_wr(host_wr), .host_rd(host_rd),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_irq(host_irq),
      .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
      .ram_address(ram_address), .ram_data(ram_data),
      .w_r_ram(w_r_ram), .go(go),
      .first_ram_address(first_ram_address),
      .last_ram_address(last_ram_address),
      .reg_num(reg_num), .reg_w_r(reg_w_r),
      .reg_write_data(reg_write_data), .interuptt(interuptt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [95:0] got,
                      input logic [95:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [90:0] pdata(input int a);
      logic [12:0] v;
      v = 13'(a * 3 + 1);
      return {7{v}};
   endfunction

   task automatic hwr(input logic [5:0] a, input logic [31:0] d);
      host_wr = 1'b1;
      host_addr = a;
      host_wdata = d;
      @(posedge clk); #1;
      host_wr = 1'b0;
   endtask

   task automatic hrd_chk(input string tag, input logic [5:0] a,
                          input logic [31:0] exp);
      host_rd = 1'b1;
      host_addr = a;
      @(posedge clk); #1;
      host_rd = 1'b0;
      chk(tag, host_rdata, exp);
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic run_load(input int first, input int last,
                           input int mode, input bit poke);
      logic [8:0]  wa[$];
      logic [90:0] wd[$];
      int k, go_n, go_c, wr_c, first_c;
      bit acc;
      k = 0; go_n = 0; go_c = -1; wr_c = -1; first_c = -1;
      pt_valid = 1'b1;
      pt_data = pdata(first);
      hwr(6'h00, 32'h1);
      for (int c = 0; c < 40; c++) begin
         pt_valid = (mode == 0) ? 1'b1 : (c % 3 == 0);
         pt_data = pdata(first + k);
         if (poke && c == 2) begin
            host_wr = 1'b1;
            host_addr = 6'h02;
            host_wdata = 32'h0;
         end else begin
            host_wr = 1'b0;
         end
         if (w_r_ram) begin
            wa.push_back(ram_address);
            wd.push_back(ram_data);
            if (first_c < 0) first_c = c;
            wr_c = c;
         end
         if (go) begin
            go_n++;
            go_c = c;
         end
         acc = pt_valid && pt_ready;
         tick();
         if (acc) k++;
      end
      pt_valid = 1'b0;
      host_wr = 1'b0;
      chk("nwr", wa.size(), last - first + 1);
      foreach (wa[i]) begin
         chk("addr", wa[i], first + i);
         chk("data", wd[i], pdata(first + i));
      end
      chk("accepts", k, last - first + 1);
      chk("go_n", go_n, 1);
      chk("go_lat", go_c, wr_c + 1);
      if (mode == 0) chk("wr_lat", first_c, 1);
   endtask

   initial begin
      int gcnt;
      rst = 1'b1;
      host_wr = 0; host_rd = 0; host_addr = 0; host_wdata = 0;
      pt_valid = 0; pt_data = 0;
      reg_num = 0; reg_w_r = 0; reg_write_data = 0; interuptt = 0;
      repeat (3) tick();
      chk("rst_ready", pt_ready, 0);
      chk("rst_go", go, 0);
      chk("rst_wr", w_r_ram, 0);
      chk("rst_irq", host_irq, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_rdata", host_rdata, 0);
      chk("rst_first", first_ram_address, 0);
      rst = 1'b0;
      tick();
      hrd_chk("rst_status", 6'h01, 32'h0);
      hrd_chk("rst_ptcnt", 6'h04, 32'h0);

      hwr(6'h02, 32'd5);
      hwr(6'h03, 32'd8);
      hrd_chk("first", 6'h02, 32'd5);
      hrd_chk("last", 6'h03, 32'd8);
      chk("last_out", last_ram_address, 8);

      run_load(5, 8, 0, 1'b0);
      hrd_chk("ptcnt4", 6'h04, 32'd4);
      hrd_chk("stat_run", 6'h01, 32'h19);

      hwr(6'h00, 32'h1);
      hrd_chk("start_in_run", 6'h01, 32'h19);
      chk("ready_in_run", pt_ready, 0);
      hrd_chk("ptcnt_kept", 6'h04, 32'd4);

      reg_w_r = 1; reg_num = 3; reg_write_data = D3;
      tick();
      reg_num = 5; reg_write_data = D5; interuptt = 1;
      tick();
      reg_w_r = 0; interuptt = 0;
      hrd_chk("stat_done", 6'h01, 32'h23);
      chk("irq_off", host_irq, 0);
      hrd_chk("c3w0", 6'h1C, 32'hEF012345);
      hrd_chk("c3w1", 6'h1D, 32'h6789ABCD);
      hrd_chk("c3w2", 6'h1E, 32'h00012345);
      hrd_chk("c3w3", 6'h1F, 32'h0);
      hrd_chk("c5w0", 6'h24, 32'hDDDEEEEF);
      hrd_chk("c5w2", 6'h26, 32'h0005AAAB);

      reg_w_r = 1; reg_num = 3; reg_write_data = '0;
      tick();
      reg_w_r = 0;
      hrd_chk("wr_in_done", 6'h1C, 32'hEF012345);

      hwr(6'h00, 32'h2);
      chk("irq_on", host_irq, 1);
      hrd_chk("ctrl_rb", 6'h00, 32'h2);
      hrd_chk("stat_hold", 6'h01, 32'h23);

      hwr(6'h00, 32'h5);
      gcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (go || pt_ready) gcnt++;
         tick();
      end
      chk("clr_start_go", gcnt, 0);
      hrd_chk("stat_idle", 6'h01, 32'h0);
      hrd_chk("cent_hold", 6'h1C, 32'hEF012345);

      run_load(5, 8, 1, 1'b1);
      hrd_chk("first_kept", 6'h02, 32'd5);
      chk("first_out", first_ram_address, 5);
      hrd_chk("ptcnt_bp", 6'h04, 32'd4);
      hrd_chk("cent_clr", 6'h1C, 32'h0);

      reg_w_r = 1; reg_num = 8; reg_write_data = '1;
      tick();
      reg_w_r = 0;
      hrd_chk("stat_err_run", 6'h01, 32'h1D);
      hrd_chk("slot0_same", 6'h10, 32'h0);
      interuptt = 1;
      tick();
      interuptt = 0;
      hrd_chk("stat_err_done", 6'h01, 32'h27);
      hwr(6'h00, 32'h4);
      hrd_chk("stat_clr", 6'h01, 32'h0);

      hwr(6'h02, 32'd10);
      hwr(6'h03, 32'd9);
      hwr(6'h00, 32'h1);
      chk("bad_ready", pt_ready, 0);
      hrd_chk("stat_bad", 6'h01, 32'h4);
      hwr(6'h00, 32'h4);
      hrd_chk("stat_bad_clr", 6'h01, 32'h0);

      hwr(6'h02, 32'd20);
      hwr(6'h03, 32'd25);
      hrd_chk("first20", 6'h02, 32'd20);
      pt_valid = 1;
      pt_data = pdata(20);
      hwr(6'h00, 32'h1);
      tick();
      pt_data = pdata(21);
      tick();
      pt_valid = 0;
      chk("pre_rst_addr", ram_address, 21);
      rst = 1'b1;
      #1;
      chk("arst_ready", pt_ready, 0);
      chk("arst_wr", w_r_ram, 0);
      chk("arst_addr", ram_address, 0);
      chk("arst_data", ram_data, 0);
      chk("arst_rdata", host_rdata, 0);
      chk("arst_first", first_ram_address, 0);
      chk("arst_last", last_ram_address, 0);
      tick();
      rst = 1'b0;
      tick();
      hrd_chk("arst_stat", 6'h01, 32'h0);
      hrd_chk("arst_ptcnt", 6'h04, 32'h0);
      hwr(6'h02, 32'd20);
      hwr(6'h03, 32'd25);
      run_load(20, 25, 0, 1'b0);
      hrd_chk("ptcnt6", 6'h04, 32'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
